// File: rtl/sr_key_conditioner.sv
// Two-key pushbutton front end: sync, debounce and pulse-stretch each key, then
// arbitrate so the SR latch downstream never sees S and R high together.
module sr_key_conditioner #(
    parameter int CNT_W     = 20,
    parameter int DEBOUNCE  = 500000,
    parameter int PULSE_LEN = 1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic KEY_S_n,
    input  logic KEY_R_n,
    output logic S,
    output logic R,
    output logic S_lvl,
    output logic R_lvl,
    output logic Conflict
);

    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE - 1);
    localparam logic [PW-1:0]    PULSE_LOAD = PW'(PULSE_LEN);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, REL_CHK} state_t;

    // Channel 0 is the set key, channel 1 the reset key.
    logic [1:0] w_key_n;
    logic [1:0] w_press;
    logic [1:0] w_lvl;

    assign w_key_n = {KEY_R_n, KEY_S_n};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic             r_s1;
            logic             r_s2;
            state_t           r_state;
            state_t           w_state_next;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_next;
            logic             r_lvl;
            logic             w_lvl_next;
            logic             w_press_evt;

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    r_s1    <= 1'b1;
                    r_s2    <= 1'b1;
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_lvl   <= 1'b0;
                end else begin
                    r_s1    <= w_key_n[gi];
                    r_s2    <= r_s1;
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                    r_lvl   <= w_lvl_next;
                end
            end

            // The press event is combinational so the pulse register rises on the
            // same edge that sets the level.
            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                w_lvl_next   = r_lvl;
                w_press_evt  = 1'b0;
                case (r_state)
                    IDLE: begin
                        if (!r_s2) begin
                            w_state_next = PRESS_CHK;
                            w_cnt_next   = '0;
                        end
                    end
                    PRESS_CHK: begin
                        if (r_s2) begin
                            w_state_next = IDLE;
                            w_cnt_next   = '0;
                        end else if (r_cnt == CNT_MAX) begin
                            w_state_next = PRESSED;
                            w_cnt_next   = '0;
                            w_lvl_next   = 1'b1;
                            w_press_evt  = 1'b1;
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (r_s2) begin
                            w_state_next = REL_CHK;
                            w_cnt_next   = '0;
                        end
                    end
                    REL_CHK: begin
                        if (!r_s2) begin
                            w_state_next = PRESSED;
                            w_cnt_next   = '0;
                        end else if (r_cnt == CNT_MAX) begin
                            w_state_next = IDLE;
                            w_cnt_next   = '0;
                            w_lvl_next   = 1'b0;
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                        w_lvl_next   = 1'b0;
                    end
                endcase
            end

            assign w_press[gi] = w_press_evt;
            assign w_lvl[gi]   = r_lvl;
        end
    endgenerate

    logic [PW-1:0] r_s_cnt;
    logic [PW-1:0] r_r_cnt;
    logic [PW-1:0] w_s_cnt_next;
    logic [PW-1:0] w_r_cnt_next;
    logic          w_s_active;
    logic          w_r_active;
    logic          w_conflict_next;
    logic          r_s;
    logic          r_r;
    logic          r_conflict;

    assign w_s_active = (r_s_cnt != '0);
    assign w_r_active = (r_r_cnt != '0);

    // R wins every collision; an accepted R event also clears a running S pulse.
    always_comb begin
        w_s_cnt_next    = r_s_cnt;
        w_r_cnt_next    = r_r_cnt;
        w_conflict_next = 1'b0;
        if (w_s_active) w_s_cnt_next = r_s_cnt - PW'(1);
        if (w_r_active) w_r_cnt_next = r_r_cnt - PW'(1);
        if (w_press[1] && !w_r_active) begin
            w_r_cnt_next = PULSE_LOAD;
            w_s_cnt_next = '0;
            if (w_s_active) w_conflict_next = 1'b1;
        end else if (w_press[0] && !w_s_active && !w_r_active) begin
            w_s_cnt_next = PULSE_LOAD;
        end
        if (w_press[0] && (w_press[1] || w_r_active)) w_conflict_next = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s_cnt    <= '0;
            r_r_cnt    <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_s_cnt    <= w_s_cnt_next;
            r_r_cnt    <= w_r_cnt_next;
            r_s        <= (w_s_cnt_next != '0);
            r_r        <= (w_r_cnt_next != '0);
            r_conflict <= w_conflict_next;
        end
    end

    assign S        = r_s;
    assign R        = r_r;
    assign S_lvl    = w_lvl[0];
    assign R_lvl    = w_lvl[1];
    assign Conflict = r_conflict;

endmodule

// File: tb/tb_sr_key_conditioner.sv
// Directed bench for sr_key_conditioner with DEBOUNCE=4; a second instance uses
// PULSE_LEN=4 for the pulse-cut scenario. Vectors are {S,R,S_lvl,R_lvl,Conflict}.
module tb_sr_key_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ks_n = 1'b1;
    logic kr_n = 1'b1;
    logic s, r, sl, rl, cf;
    logic k4s_n = 1'b1;
    logic k4r_n = 1'b1;
    logic s4, r4, sl4, rl4, cf4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sr_key_conditioner #(.CNT_W(4), .DEBOUNCE(4), .PULSE_LEN(2)) u_dut (
        .Clk(clk), .Reset(rst), .KEY_S_n(ks_n), .KEY_R_n(kr_n),
        .S(s), .R(r), .S_lvl(sl), .R_lvl(rl), .Conflict(cf)
    );

    sr_key_conditioner #(.CNT_W(4), .DEBOUNCE(4), .PULSE_LEN(4)) u_dut4 (
        .Clk(clk), .Reset(rst), .KEY_S_n(k4s_n), .KEY_R_n(k4r_n),
        .S(s4), .R(r4), .S_lvl(sl4), .R_lvl(rl4), .Conflict(cf4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({s, r, sl, rl, cf} !== 5'b0) begin
            bad++;
            $display("FAIL reset_async dut got=%b exp=00000", {s, r, sl, rl, cf});
        end
        total++;
        if ({s4, r4, sl4, rl4, cf4} !== 5'b0) begin
            bad++;
            $display("FAIL reset_async dut4 got=%b exp=00000", {s4, r4, sl4, rl4, cf4});
        end
        tick();
        tick();
        total++;
        if ({s, r, sl, rl, cf} !== 5'b0) begin
            bad++;
            $display("FAIL reset_held dut got=%b exp=00000", {s, r, sl, rl, cf});
        end
        rst = 1'b0;
        tick();
        tick();
        total++;
        if ({s, r, sl, rl, cf} !== 5'b0) begin
            bad++;
            $display("FAIL reset_release dut got=%b exp=00000", {s, r, sl, rl, cf});
        end
    endtask

    task automatic test_s_press();
        logic [4:0] exp;
        ks_n = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp = {(e == 7 || e == 8), 1'b0, (e >= 7), 1'b0, 1'b0};
            total++;
            if ({s, r, sl, rl, cf} !== exp) begin
                bad++;
                $display("FAIL s_press e=%0d got=%b exp=%b", e, {s, r, sl, rl, cf}, exp);
            end
        end
        ks_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = {1'b0, 1'b0, (e < 7), 1'b0, 1'b0};
            total++;
            if ({s, r, sl, rl, cf} !== exp) begin
                bad++;
                $display("FAIL s_release e=%0d got=%b exp=%b", e, {s, r, sl, rl, cf}, exp);
            end
        end
    endtask

    task automatic test_r_bounce();
        logic [4:0] exp;
        for (int e = 1; e <= 18; e++) begin
            kr_n = (e == 3 || e == 6);
            tick();
            exp = {1'b0, (e == 13 || e == 14), 1'b0, (e >= 13), 1'b0};
            total++;
            if ({s, r, sl, rl, cf} !== exp) begin
                bad++;
                $display("FAIL r_bounce e=%0d got=%b exp=%b", e, {s, r, sl, rl, cf}, exp);
            end
        end
        kr_n = 1'b1;
        repeat (8) tick();
        total++;
        if ({s, r, sl, rl, cf} !== 5'b0) begin
            bad++;
            $display("FAIL r_release got=%b exp=00000", {s, r, sl, rl, cf});
        end
    endtask

    task automatic test_both();
        logic [4:0] exp;
        ks_n = 1'b0;
        kr_n = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp = {1'b0, (e == 7 || e == 8), (e >= 7), (e >= 7), (e == 7)};
            total++;
            if ({s, r, sl, rl, cf} !== exp) begin
                bad++;
                $display("FAIL both e=%0d got=%b exp=%b", e, {s, r, sl, rl, cf}, exp);
            end
        end
        ks_n = 1'b1;
        kr_n = 1'b1;
        repeat (8) tick();
        total++;
        if ({s, r, sl, rl, cf} !== 5'b0) begin
            bad++;
            $display("FAIL both_release got=%b exp=00000", {s, r, sl, rl, cf});
        end
    endtask

    task automatic test_cut();
        logic [4:0] exp;
        k4s_n = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            if (e == 2) k4r_n = 1'b0;
            tick();
            exp = {(e == 7), (e >= 8 && e <= 11), (e >= 7), (e >= 8), (e == 8)};
            total++;
            if ({s4, r4, sl4, rl4, cf4} !== exp) begin
                bad++;
                $display("FAIL cut e=%0d got=%b exp=%b", e, {s4, r4, sl4, rl4, cf4}, exp);
            end
            total++;
            if ((s4 & r4) !== 1'b0) begin
                bad++;
                $display("FAIL cut_exclusive e=%0d got=%b exp=0", e, s4 & r4);
            end
        end
        k4s_n = 1'b1;
        k4r_n = 1'b1;
        repeat (8) tick();
        total++;
        if ({s4, r4, sl4, rl4, cf4} !== 5'b0) begin
            bad++;
            $display("FAIL cut_release got=%b exp=00000", {s4, r4, sl4, rl4, cf4});
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp;
        ks_n = 1'b0;
        repeat (7) tick();
        total++;
        if ({s, sl} !== 2'b11) begin
            bad++;
            $display("FAIL pre_reset_pulse got=%b exp=11", {s, sl});
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({s, sl} !== 2'b00) begin
            bad++;
            $display("FAIL reset_async_drop got=%b exp=00", {s, sl});
        end
        tick();
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp = {(e == 7 || e == 8), 1'b0, (e >= 7), 1'b0, 1'b0};
            total++;
            if ({s, r, sl, rl, cf} !== exp) begin
                bad++;
                $display("FAIL reset_repress e=%0d got=%b exp=%b", e, {s, r, sl, rl, cf}, exp);
            end
        end
        ks_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_glitch_release();
        logic [4:0] exp;
        ks_n = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp = {(e == 7 || e == 8), 1'b0, (e >= 7), 1'b0, 1'b0};
            total++;
            if ({s, r, sl, rl, cf} !== exp) begin
                bad++;
                $display("FAIL glitch_press e=%0d got=%b exp=%b", e, {s, r, sl, rl, cf}, exp);
            end
        end
        for (int e = 1; e <= 14; e++) begin
            ks_n = !(e == 3 || e == 4);
            tick();
            exp = {1'b0, 1'b0, (e < 11), 1'b0, 1'b0};
            total++;
            if ({s, r, sl, rl, cf} !== exp) begin
                bad++;
                $display("FAIL glitch_release e=%0d got=%b exp=%b", e, {s, r, sl, rl, cf}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_s_press();
        test_r_bounce();
        test_both();
        test_cut();
        test_reset_mid();
        test_glitch_release();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
